tc_stream_exe_ctrl: RTL
=======================

// Module: tc_stream_exe_ctrl
// PURPOSE
// - Parametrised stream front/back end for the tensor-core datapath.
// - Joins the A/B/C AXI-Stream operand channels into one issue beat to the compute core.
// - Bounds in-flight work with a credit counter and buffers results in a FIFO of depth FIFO_DEPTH.
// - Emits D as AXI-Stream with tile-accurate tlast, plus busy/irq; sits between the DMA streams and tensor_core.
// PARAMETERS
// - DATA_W      256   width of A/B/C operand beats (one bus beat each)
// - RES_W       1024  width of one core result beat / D beat
// - TAG_W       10    sideband tag (reg idx + warp id), carried core-in -> core-out -> m_axis_tuser_d
// - FIFO_DEPTH  4     result FIFO entries; power of 2, >=2
// - CNT_W       16    width of the tile beat counters
// PORTS
// - clk              in   1          clock
// - rst              in   1          async reset, active-high
// - en               in   1          start/run enable (level)
// - tile_beats       in   CNT_W      beats per tile; sampled on start
// - tag_i            in   TAG_W      tag attached to each issued beat
// - irq_en           in   2          per-bit irq enable
// - busy             out  1          state != IDLE
// - irq              out  2          [0] done pulse, [1] protocol error (level)
// - s_axis_t{data,valid,last}_{a,b,c}   in    DATA_W/1/1   operand streams
// - s_axis_tready_{a,b,c}               out   1            operand ready
// - core_in_valid / core_in_ready       out/in 1           issue handshake
// - core_a / core_b / core_c            out   DATA_W       issued operands
// - core_tag                            out   TAG_W        issued tag
// - core_out_valid / core_out_data / core_out_tag   in  1/RES_W/TAG_W   result (no ready)
// - m_axis_t{valid,data,last,user}_d    out   1/RES_W/1/TAG_W   result stream
// - m_axis_tready_d                     in    1            result ready
// BEHAVIOUR
// - Reset: state=IDLE; all ready/valid/last/irq/busy = 0; counters, inflight, FIFO pointers, err = 0.
// - FSM IDLE->RUN: en=1 and tile_beats!=0; latch tile_beats; clear issue/out counters and err. tile_beats==0: stay IDLE.
// - RUN: issue = tvalid_a & tvalid_b & tvalid_c & core_in_ready & (credit>0) & en.
//   - All three tready = issue, same cycle; core_in_valid = issue. core_* = stream data, combinational pass-through.
// - credit = FIFO_DEPTH - fifo_count - inflight.
//   - inflight +1 on issue, -1 on core_out_valid; both in one cycle: unchanged.
//   - Credits are the only backpressure for core results; core_out_valid with FIFO full is illegal (assertion).
// - RUN->DRAIN: issue_cnt reaches latched tile_beats, or any issued tlast, or en=0 (abort).
//   - A/B/C tlast disagreeing on an issued beat sets err.
//   - Any tlast before the final beat, or no tlast on the final beat, sets err.
//   - err is sticky until the next start.
// - DRAIN: no issue, treadys=0. DRAIN->DONE when inflight==0, FIFO empty, and no D beat pending.
// - DONE: 1 cycle, irq[0] pulses if irq_en[0], then ->IDLE.
// - irq[1] = err & irq_en[1].
// - FIFO: written on core_out_valid with {data,tag}.
//   - m_axis_tvalid_d = !empty, data from FIFO head register.
//   - Latency core_out -> m_axis_tvalid_d = 1 cycle. Read and write in the same cycle are legal at any occupancy.
// - m_axis_tlast_d = 1 on the out_cnt==tile_beats-1 beat. On abort, tlast is forced on the last drained beat.
// - out_cnt increments on tvalid&tready.
// - Counters wrap never: CNT_W bounds tile_beats; issue stops at tile_beats.
// - rst mid-operation: immediate return to reset state. FIFO contents and in-flight results are dropped; the core is reset by the same rst.
// CONFIGURATION
// - `TC_EXE_PERF_CNT_EN defined: adds outputs perf_stall_in (32b) and perf_stall_out (32b).
//   - perf_stall_in counts RUN cycles with all tvalid=1 but no issue.
//   - perf_stall_out counts cycles with m_axis_tvalid_d & !m_axis_tready_d.
//   - Both cleared on start, saturating.
// - Not defined: ports absent, no counter logic.
// STRUCTURE
// - Package tc_exe_pkg: FSM state encoding (IDLE/RUN/DRAIN/DONE), IRQ bit indices (IRQ_DONE=0, IRQ_ERR=1), clog2 helper for pointer widths.
// - Sub-module tc_res_fifo: sync FIFO, FIFO_DEPTH x (RES_W+TAG_W), registered head, count output.
// - Top holds FSM, join/credit logic, counters, tlast gen, irq.
// TESTING
// - Smoke: tile_beats=4, core model latency 3, m ready=1, tlast on beat 3.
//   -> 4 D beats, tlast only on 4th, tuser=tag_i, irq[0] pulse 1 cycle, busy back to 0.
// - Backpressure: m_axis_tready_d=0 for 20 cycles, FIFO_DEPTH=4, tile_beats=8.
//   -> at most 4 issues before stall, no overflow assertion, all 8 beats delivered in order.
// - Skewed valids: tvalid_c lags A/B by 5 cycles.
//   -> no tready/issue until C valid; then one issue with all three treadys high together.
// - Protocol error: tlast_a=1 on beat 2 of tile_beats=4, tlast_b/c=0.
//   -> err set, irq[1]=1 (irq_en=2'b11), RUN->DRAIN, D beat 2 carries tlast, irq[0] pulses.
// - Abort/reset: en=0 after 3 issues -> drain 3 beats, last with tlast, DONE.
//   - Separate run: rst pulse mid-RUN -> all outputs 0 next edge, FIFO empty.
// - `TC_EXE_PERF_CNT_EN: 10 cycles ready-low with valid D -> perf_stall_out=10.

Source files
------------

// File: rtl/tc_exe_pkg.sv
// Shared types for the tensor-core stream execution controller:
// FSM encoding, irq bit positions and a pointer-width helper.
package tc_exe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int IRQ_DONE = 0;
  localparam int IRQ_ERR  = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/tc_res_fifo.sv
// Result FIFO between core output and the D stream.
// Head entry is read straight from the storage registers.
module tc_res_fifo
  import tc_exe_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en_i,
  input  logic [W-1:0]            wr_data_i,
  input  logic                    rd_en_i,
  output logic [W-1:0]            rd_data_o,
  output logic                    empty_o,
  output logic [clog2(DEPTH):0]   count_o
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          full;

  assign full      = cnt_q == CW'(DEPTH);
  assign empty_o   = cnt_q == '0;
  assign count_o   = cnt_q;
  assign rd_data_o = mem_q[rp_q];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wp_q] <= wr_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en_i) wp_q <= wp_q + 1'b1;
      if (rd_en_i) rp_q <= rp_q + 1'b1;
      case ({wr_en_i, rd_en_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Credits upstream must make a write into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(wr_en_i && !rd_en_i && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(rd_en_i && empty_o));

endmodule

// File: rtl/tc_stream_exe_ctrl.sv
// A/B/C operand join, credit-bounded issue, result FIFO and D stream.
// Optional stall counters: define TC_EXE_PERF_CNT_EN.
module tc_stream_exe_ctrl
  import tc_exe_pkg::*;
#(
  parameter int DATA_W     = 256,
  parameter int RES_W      = 1024,
  parameter int TAG_W      = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  tile_beats,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [1:0]        irq_en,
  output logic              busy,
  output logic [1:0]        irq,
  input  logic [DATA_W-1:0] s_axis_tdata_a,
  input  logic              s_axis_tvalid_a,
  input  logic              s_axis_tlast_a,
  output logic              s_axis_tready_a,
  input  logic [DATA_W-1:0] s_axis_tdata_b,
  input  logic              s_axis_tvalid_b,
  input  logic              s_axis_tlast_b,
  output logic              s_axis_tready_b,
  input  logic [DATA_W-1:0] s_axis_tdata_c,
  input  logic              s_axis_tvalid_c,
  input  logic              s_axis_tlast_c,
  output logic              s_axis_tready_c,
  output logic              core_in_valid,
  input  logic              core_in_ready,
  output logic [DATA_W-1:0] core_a,
  output logic [DATA_W-1:0] core_b,
  output logic [DATA_W-1:0] core_c,
  output logic [TAG_W-1:0]  core_tag,
  input  logic              core_out_valid,
  input  logic [RES_W-1:0]  core_out_data,
  input  logic [TAG_W-1:0]  core_out_tag,
`ifdef TC_EXE_PERF_CNT_EN
  output logic [31:0]       perf_stall_in,
  output logic [31:0]       perf_stall_out,
`endif
  output logic              m_axis_tvalid_d,
  output logic [RES_W-1:0]  m_axis_tdata_d,
  output logic              m_axis_tlast_d,
  output logic [TAG_W-1:0]  m_axis_tuser_d,
  input  logic              m_axis_tready_d
);

  localparam int PW  = clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] DEPTH_C = CW1'(FIFO_DEPTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tile_q, tile_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;
  logic [CNT_W-1:0] ocnt_q, ocnt_d;
  logic [CW-1:0]    infl_q, infl_d;
  logic             err_q, err_d;
  logic             early_q, early_d;

  logic [CW-1:0]          fcnt;
  logic                   f_empty;
  logic [RES_W+TAG_W-1:0] f_head;

  logic all_valid, credit_ok, issue, start, rd;
  logic last_any, last_all, final_beat, bad_last;
  logic end_early, drain_last;

  assign all_valid = s_axis_tvalid_a & s_axis_tvalid_b & s_axis_tvalid_c;
  assign credit_ok = ({1'b0, fcnt} + {1'b0, infl_q}) < DEPTH_C;
  assign issue     = (state_q == RUN) & all_valid & core_in_ready
                   & credit_ok & en;
  assign start     = (state_q == IDLE) & en & (tile_beats != '0);
  assign rd        = m_axis_tvalid_d & m_axis_tready_d;

  assign last_any   = s_axis_tlast_a | s_axis_tlast_b | s_axis_tlast_c;
  assign last_all   = s_axis_tlast_a & s_axis_tlast_b & s_axis_tlast_c;
  assign final_beat = icnt_q == tile_q - 1'b1;
  assign bad_last   = (last_any != last_all) | (last_any != final_beat);

  assign s_axis_tready_a = issue;
  assign s_axis_tready_b = issue;
  assign s_axis_tready_c = issue;
  assign core_in_valid   = issue;
  assign core_a          = s_axis_tdata_a;
  assign core_b          = s_axis_tdata_b;
  assign core_c          = s_axis_tdata_c;
  assign core_tag        = tag_i;

  assign busy = state_q != IDLE;

  always_comb begin
    irq           = '0;
    irq[IRQ_DONE] = (state_q == DONE) & irq_en[IRQ_DONE];
    irq[IRQ_ERR]  = err_q & irq_en[IRQ_ERR];
  end

  always_comb begin
    state_d = state_q;
    tile_d  = tile_q;
    icnt_d  = icnt_q;
    ocnt_d  = ocnt_q;
    err_d   = err_q;
    early_d = early_q;
    if (issue) begin
      icnt_d = icnt_q + 1'b1;
      if (bad_last) err_d = 1'b1;
    end
    if (rd) ocnt_d = ocnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          tile_d  = tile_beats;
          icnt_d  = '0;
          ocnt_d  = '0;
          err_d   = 1'b0;
          early_d = 1'b0;
        end
      end
      RUN: begin
        if (!en || (issue && (final_beat || last_any))) begin
          state_d = DRAIN;
          early_d = !(issue && final_beat);
        end
      end
      DRAIN: begin
        if (infl_q == '0 && f_empty) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case ({issue, core_out_valid})
      2'b10:   infl_d = infl_q + 1'b1;
      2'b01:   infl_d = infl_q - 1'b1;
      default: infl_d = infl_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tile_q  <= '0;
      icnt_q  <= '0;
      ocnt_q  <= '0;
      infl_q  <= '0;
      err_q   <= 1'b0;
      early_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      icnt_q  <= icnt_d;
      ocnt_q  <= ocnt_d;
      infl_q  <= infl_d;
      err_q   <= err_d;
      early_q <= early_d;
    end
  end

  tc_res_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (RES_W + TAG_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (core_out_valid),
    .wr_data_i ({core_out_data, core_out_tag}),
    .rd_en_i   (rd),
    .rd_data_o (f_head),
    .empty_o   (f_empty),
    .count_o   (fcnt)
  );

  // A short tile closes on whichever beat leaves the datapath last.
  assign end_early  = early_q | ((state_q == RUN) & ~en);
  assign drain_last = end_early & (infl_q == '0) & (fcnt == CW'(1));

  assign m_axis_tvalid_d = ~f_empty;
  assign m_axis_tdata_d  = f_head[RES_W+TAG_W-1:TAG_W];
  assign m_axis_tuser_d  = f_head[TAG_W-1:0];
  assign m_axis_tlast_d  = m_axis_tvalid_d
                         & ((ocnt_q == tile_q - 1'b1) | drain_last);

`ifdef TC_EXE_PERF_CNT_EN
  logic [31:0] pin_q, pout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pin_q  <= '0;
      pout_q <= '0;
    end else if (start) begin
      pin_q  <= '0;
      pout_q <= '0;
    end else begin
      if ((state_q == RUN) && all_valid && !issue && (pin_q != '1))
        pin_q <= pin_q + 1'b1;
      if (m_axis_tvalid_d && !m_axis_tready_d && (pout_q != '1))
        pout_q <= pout_q + 1'b1;
    end
  end

  assign perf_stall_in  = pin_q;
  assign perf_stall_out = pout_q;
`endif

endmodule
